multicycle_rv_core: RTL and testbench

//  Multi-cycle RV32I integer core: fetch/decode/execute/memory/writeback FSM, internal register file, PC.

---
 rtl/multicycle_rv_core.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_multicycle_rv_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_rv_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_rv_core
// Purpose  : Multi-cycle RV32I integer core. A FETCH/DECODE/EXEC/MEM/WB state
//            machine steps one instruction at a time through an internal
//            register file and PC. Instruction and data memories are reached
//            through req/ready handshakes that tolerate any number of wait
//            states. Supports LUI, AUIPC, JAL, JALR, OP, OP-IMM, LB/LH/LW/
//            LBU/LHU and SB/SH/SW. Illegal encodings, out-of-range register
//            indices and misaligned accesses park the core in TRAP.
// Ports    : clk, rst_n            clock (rising edge), async active-low reset
//            imem_req/addr         fetch request, address = pc
//            imem_ready/rdata      fetch completion and instruction word
//            dmem_req/we/addr      data request, store flag, byte address
//            dmem_wdata/wstrb      lane-replicated store data, byte enables
//            dmem_ready/rdata      access completion and aligned load word
//            retire                one-cycle pulse per completed instruction
//            trap                  sticky fault indication
//            dbg_addr/dbg_data     combinational register file read port
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_rv_core #(
  parameter int                XLEN     = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            trap,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [5:0]      NREG    = 6'(NUM_REGS);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t          state, next_state;

  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] next_pc;
  // Always 32 entries; indices at or above NUM_REGS trap in DECODE, so the
  // upper entries of an RV32E build are never written and stay zero.
  logic [XLEN-1:0] regs [32];

  // --------------------------------------------------------------------------
  // Instruction fields and immediates
  // --------------------------------------------------------------------------
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  logic            is_store, is_mem;
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = (opcode == OPC_LOAD) || is_store;

  // --------------------------------------------------------------------------
  // Decode: legality, register usage and immediate selection
  // --------------------------------------------------------------------------
  logic            dec_legal, uses_rs1, uses_rs2, uses_rd, bad_reg;
  logic [XLEN-1:0] imm_dec;

  always_comb begin
    dec_legal = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    uses_rd   = 1'b0;
    imm_dec   = imm_i;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        uses_rd   = 1'b1;
        imm_dec   = imm_u;
      end
      OPC_JAL: begin
        dec_legal = 1'b1;
        uses_rd   = 1'b1;
        imm_dec   = imm_j;
      end
      OPC_JALR: begin
        dec_legal = (funct3 == 3'b000);
        uses_rs1  = 1'b1;
        uses_rd   = 1'b1;
      end
      OPC_OP: begin
        // funct7 = 0x20 is only meaningful for SUB and SRA.
        dec_legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        uses_rd   = 1'b1;
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)
          dec_legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
          dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else
          dec_legal = 1'b1;
        uses_rs1  = 1'b1;
        uses_rd   = 1'b1;
      end
      OPC_LOAD: begin
        dec_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        uses_rs1  = 1'b1;
        uses_rd   = 1'b1;
      end
      OPC_STORE: begin
        dec_legal = !funct3[2] && (funct3[1:0] != 2'b11);
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        imm_dec   = imm_s;
      end
      default: dec_legal = 1'b0;
    endcase
    bad_reg = (uses_rs1 && ({1'b0, rs1} >= NREG)) ||
              (uses_rs2 && ({1'b0, rs2} >= NREG)) ||
              (uses_rd  && ({1'b0, rd}  >= NREG));
  end

  // --------------------------------------------------------------------------
  // Execute: ALU, jump targets, effective address and alignment
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] op2, alu_out, eff_addr, pc_plus4;
  logic [XLEN-1:0] exec_result, exec_next_pc;
  logic [4:0]      shamt;
  logic            misaligned;

  assign op2      = (opcode == OPC_OP) ? rs2_val : imm;
  assign shamt    = op2[4:0];
  assign eff_addr = rs1_val + imm;
  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000: alu_out = ((opcode == OPC_OP) && funct7[5]) ? (rs1_val - op2) : (rs1_val + op2);
      3'b001: alu_out = rs1_val << shamt;
      3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op2))};
      3'b011: alu_out = {{(XLEN-1){1'b0}}, (rs1_val < op2)};
      3'b100: alu_out = rs1_val ^ op2;
      3'b101: alu_out = funct7[5] ? XLEN'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      3'b110: alu_out = rs1_val | op2;
      3'b111: alu_out = rs1_val & op2;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    exec_result  = alu_out;
    exec_next_pc = pc_plus4;
    misaligned   = 1'b0;
    case (opcode)
      OPC_LUI:   exec_result = imm;
      OPC_AUIPC: exec_result = pc + imm;
      OPC_JAL: begin
        exec_result  = pc_plus4;
        exec_next_pc = pc + imm;
      end
      OPC_JALR: begin
        exec_result  = pc_plus4;
        exec_next_pc = {eff_addr[XLEN-1:1], 1'b0};
        misaligned   = eff_addr[1];
      end
      OPC_LOAD, OPC_STORE: begin
        // funct3[1:0]: 00 byte, 01 half, 10 word (same for loads and stores).
        misaligned = ((funct3[1:0] == 2'b01) && eff_addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
      end
      default: exec_result = alu_out;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory lanes: store replication/strobes and load extraction
  // --------------------------------------------------------------------------
  logic [3:0]      store_strb;
  logic [XLEN-1:0] load_shifted, load_data;

  always_comb begin
    case (funct3[1:0])
      2'b00:   store_strb = 4'b0001 << mem_addr[1:0];
      2'b01:   store_strb = mem_addr[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
    case (funct3[1:0])
      2'b00:   dmem_wdata = {4{rs2_val[7:0]}};
      2'b01:   dmem_wdata = {2{rs2_val[15:0]}};
      default: dmem_wdata = rs2_val;
    endcase
  end

  assign load_shifted = dmem_rdata >> {mem_addr[1:0], 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  assign imem_addr = pc;
  assign dmem_addr = mem_addr;
  assign dbg_data  = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_wstrb = 4'b0000;
    retire     = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        // Reset parks the FSM in FETCH; gating with rst_n keeps the request
        // low while reset is held.
        imem_req = rst_n;
        if (imem_ready) next_state = S_DECODE;
      end
      S_DECODE: next_state = (!dec_legal || bad_reg) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (misaligned)  next_state = S_TRAP;
        else if (is_mem) next_state = S_MEM;
        else             next_state = S_WB;
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        dmem_wstrb = is_store ? store_strb : 4'b0000;
        if (dmem_ready) next_state = S_WB;
      end
      S_WB: begin
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: next_state = S_TRAP;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers and register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      rs1_val  <= '0;
      rs2_val  <= '0;
      imm      <= '0;
      result   <= '0;
      mem_addr <= '0;
      next_pc  <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          rs1_val <= regs[rs1];
          rs2_val <= regs[rs2];
          imm     <= imm_dec;
        end
        S_EXEC: begin
          result   <= exec_result;
          next_pc  <= exec_next_pc;
          mem_addr <= eff_addr;
        end
        S_MEM: if (dmem_ready && !is_store) result <= load_data;
        S_WB: begin
          pc <= next_pc;
          if (uses_rd && (rd != 5'd0)) regs[rd] <= result;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_rv_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_rv_core
// Purpose  : Directed self-checking bench for multicycle_rv_core. Behavioural
//            instruction/data memory responders with programmable wait
//            states; a linear sequence of programs with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_rv_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, dmem_req, dmem_we, retire, trap;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, dbg_data;
  logic [3:0]  dmem_wstrb;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [4:0]  dbg_addr;

  multicycle_rv_core #(.XLEN(32), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .trap       (trap),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] imem [64];
  int          imem_wait, dmem_wait;
  logic [31:0] dmem_load_data;

  // Responder bookkeeping (written only by the responders)
  int          imem_cnt = 0, dmem_cnt = 0;
  int          fetch_cnt = 0, addr_glitch = 0, dmem_seen = 0;
  logic        imem_req_prev = 1'b0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] st_addr = 32'h0, st_wdata = 32'h0;
  logic [3:0]  st_strb = 4'h0;
  logic        st_we = 1'b0;

  always @(negedge clk) begin
    if (imem_req) begin
      if (imem_req_prev && (imem_addr !== held_addr)) addr_glitch++;
      held_addr = imem_addr;
      if (imem_cnt == imem_wait) begin
        imem_ready = 1'b1;
        imem_rdata = imem[imem_addr[7:2]];
        imem_cnt   = 0;
        fetch_cnt++;
      end else begin
        imem_ready = 1'b0;
        imem_cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      imem_cnt   = 0;
    end
    imem_req_prev = imem_req;
  end

  always @(negedge clk) begin
    if (dmem_req) begin
      dmem_seen++;
      if (dmem_cnt == dmem_wait) begin
        dmem_ready = 1'b1;
        dmem_rdata = dmem_load_data;
        st_addr    = dmem_addr;
        st_wdata   = dmem_wdata;
        st_strb    = dmem_wstrb;
        st_we      = dmem_we;
        dmem_cnt   = 0;
      end else begin
        dmem_ready = 1'b0;
        dmem_cnt++;
      end
    end else begin
      dmem_ready = 1'b0;
      dmem_cnt   = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic load_nops();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  // Holds reset for a few cycles, checks the reset state, releases just
  // after a rising edge.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_rst_dmem_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_rst_retire_trap_we"}, {29'd0, retire, trap, dmem_we}, 32'd0);
    check({tag, "_rst_wstrb"}, 32'(dmem_wstrb), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for the next retire pulse, then advances one more
  // falling edge so the WB writes are visible and the next fetch is up.
  task automatic retire_one(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (retire === 1'b1);
    end
    check({tag, "_retire_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, g0, d0, req_cnt, n;
    rst_n          = 1'b0;
    dbg_addr       = 5'd0;
    imem_wait      = 0;
    dmem_wait      = 0;
    dmem_load_data = 32'h0;

    // ---- 1: ADDI x1,x0,5 with zero wait states ----
    load_nops();
    imem[0] = 32'h0050_0093;
    apply_reset("t1");
    check_reg("t1_x1_after_reset", 5'd1, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t1_retire_cycle%0d", c), 32'(retire), (c == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("t1_retire_single_pulse", 32'(retire), 32'd0);
    check("t1_next_fetch_addr", imem_addr, 32'h4);
    check("t1_next_fetch_req", 32'(imem_req), 32'd1);
    check_reg("t1_x1", 5'd1, 32'h5);

    // ---- 2: same program, fetch delayed by 3 wait states ----
    imem_wait = 3;
    apply_reset("t2");
    f0 = fetch_cnt;
    g0 = addr_glitch;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("t2_retire_cycle%0d", c), 32'(retire), (c == 7) ? 32'd1 : 32'd0);
    end
    check("t2_single_fetch", 32'(fetch_cnt - f0), 32'd1);
    check("t2_addr_stable", 32'(addr_glitch - g0), 32'd0);
    @(negedge clk);
    check_reg("t2_x1", 5'd1, 32'h5);
    imem_wait = 0;

    // ---- 3: SB then LB/LBU through the data port ----
    load_nops();
    imem[0] = 32'h0050_0093; // ADDI x1,x0,5
    imem[1] = 32'h1000_0113; // ADDI x2,x0,0x100
    imem[2] = 32'h0011_00A3; // SB   x1,1(x2)
    imem[3] = 32'h0011_0183; // LB   x3,1(x2)
    imem[4] = 32'h0011_4303; // LBU  x6,1(x2)
    apply_reset("t3");
    retire_one("t3_addi1");
    retire_one("t3_addi2");
    check_reg("t3_x2", 5'd2, 32'h100);
    retire_one("t3_sb");
    check("t3_sb_addr", st_addr, 32'h101);
    check("t3_sb_wstrb", 32'(st_strb), 32'h2);
    check("t3_sb_wdata", st_wdata, 32'h0505_0505);
    check("t3_sb_we", 32'(st_we), 32'd1);
    check_reg("t3_x1_not_written_by_store", 5'd1, 32'h5);
    dmem_load_data = 32'h0000_8000;
    dmem_wait      = 2;
    retire_one("t3_lb");
    check_reg("t3_x3_lb", 5'd3, 32'hFFFF_FF80);
    check("t3_lb_we", 32'(st_we), 32'd0);
    retire_one("t3_lbu");
    check_reg("t3_x6_lbu", 5'd6, 32'h0000_0080);
    dmem_wait = 0;

    // ---- 4: misaligned LW traps without a data request ----
    load_nops();
    imem[0] = 32'h1000_0113; // ADDI x2,x0,0x100
    imem[1] = 32'h0021_2183; // LW   x3,2(x2) -> 0x102
    apply_reset("t4");
    d0 = dmem_seen;
    retire_one("t4_addi");
    repeat (4) @(negedge clk);
    check("t4_trap", 32'(trap), 32'd1);
    req_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (imem_req === 1'b1 || retire === 1'b1) req_cnt++;
    end
    check("t4_no_fetch_or_retire_after_trap", 32'(req_cnt), 32'd0);
    check("t4_trap_sticky", 32'(trap), 32'd1);
    check("t4_no_dmem_req", 32'(dmem_seen - d0), 32'd0);
    check_reg("t4_x3_unchanged", 5'd3, 32'h0);

    // ---- 5: JAL, SUB, SRAI, JALR, LUI, AUIPC, SLTU, SLT ----
    load_nops();
    imem[4]  = 32'h0080_00EF; // 0x10 JAL  x1,+8
    imem[5]  = 32'h0010_0393; // 0x14 ADDI x7,x0,1 (skipped)
    imem[6]  = 32'h0010_0493; // 0x18 ADDI x9,x0,1
    imem[7]  = 32'h4090_0233; // 0x1C SUB  x4,x0,x9
    imem[8]  = 32'h4042_5293; // 0x20 SRAI x5,x4,4
    imem[9]  = 32'h0310_0567; // 0x24 JALR x10,0x31(x0)
    imem[12] = 32'h1234_55B7; // 0x30 LUI  x11,0x12345
    imem[13] = 32'h0000_1617; // 0x34 AUIPC x12,1
    imem[14] = 32'h0040_36B3; // 0x38 SLTU x13,x0,x4
    imem[15] = 32'h0040_2733; // 0x3C SLT  x14,x0,x4
    apply_reset("t5");
    repeat (4) retire_one("t5_nop");
    retire_one("t5_jal");
    check("t5_jal_target", imem_addr, 32'h18);
    check_reg("t5_jal_link", 5'd1, 32'h14);
    retire_one("t5_addi");
    retire_one("t5_sub");
    check_reg("t5_sub", 5'd4, 32'hFFFF_FFFF);
    retire_one("t5_srai");
    check_reg("t5_srai", 5'd5, 32'hFFFF_FFFF);
    retire_one("t5_jalr");
    check("t5_jalr_target", imem_addr, 32'h30);
    check_reg("t5_jalr_link", 5'd10, 32'h28);
    retire_one("t5_lui");
    check_reg("t5_lui", 5'd11, 32'h1234_5000);
    retire_one("t5_auipc");
    check_reg("t5_auipc", 5'd12, 32'h0000_1034);
    retire_one("t5_sltu");
    check_reg("t5_sltu", 5'd13, 32'h1);
    retire_one("t5_slt");
    check_reg("t5_slt", 5'd14, 32'h0);
    check_reg("t5_skipped_x7", 5'd7, 32'h0);

    // ---- 6: reset during an outstanding data request ----
    load_nops();
    imem[0]   = 32'h1000_0113; // ADDI x2,x0,0x100
    imem[1]   = 32'h0011_0183; // LB   x3,1(x2)
    dmem_wait = 5;
    apply_reset("t6");
    retire_one("t6_addi");
    n = 0;
    while (dmem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_dmem_req_pending", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_dmem_req_drops", 32'(dmem_req), 32'd0);
    check("t6_imem_req_in_reset", 32'(imem_req), 32'd0);
    check_reg("t6_x2_cleared", 5'd2, 32'h0);
    dmem_wait = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_restart_req", 32'(imem_req), 32'd1);
    check("t6_trap_clear", 32'(trap), 32'd0);
    retire_one("t6_readdi");
    check_reg("t6_x2_again", 5'd2, 32'h100);
    check_reg("t6_x3_still_zero", 5'd3, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
